// File: rtl/adder8_pkg.sv
// -----------------------------------------------------------------------------
// adder8_pkg
// Shared definitions for the 8-bit adder result accumulator.
//   ADDER_W     : width of the adder SUM bus feeding the accumulator
//   acc_state_t : batch FSM state (IDLE -> ACCUM -> DONE -> IDLE)
// -----------------------------------------------------------------------------
package adder8_pkg;

  localparam int ADDER_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage : adder8_pkg

// File: rtl/adder8_accum.sv
// -----------------------------------------------------------------------------
// adder8_accum
// Collects {carry, sum} results from the 8-bit parallel adder over a
// valid/ready handshake and sums N_SAMPLES of them into a wide accumulator.
// The finished batch total is held with out_valid until the consumer takes it.
//
// Build option:
//   ADDER8_ACCUM_SAT_EN : when defined, the accumulator saturates to all-ones
//                         on overflow and stays there for the rest of the
//                         batch; when undefined, it wraps modulo 2^ACC_W.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   block enable; low freezes all state
//   in_valid   in   adder result present
//   in_sum     in   adder SUM [7:0]
//   in_carry   in   adder carry-out
//   in_ready   out  a result can be accepted this cycle
//   clear      in   synchronous abort (highest priority when ena is high)
//   out_valid  out  batch total available
//   out_ready  in   consumer takes the total
//   acc        out  running or final total [ACC_W-1:0]
//   count      out  results accepted in the current batch [CNT_W-1:0]
//   overflow   out  sticky: a carry left bit ACC_W-1 during this batch
// -----------------------------------------------------------------------------
module adder8_accum
  import adder8_pkg::*;
#(
  parameter int ACC_W     = 16,
  parameter int N_SAMPLES = 4,
  localparam int CNT_W    = $clog2(N_SAMPLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  input  logic [ADDER_W-1:0] in_sum,
  input  logic               in_carry,
  output logic               in_ready,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc,
  output logic [CNT_W-1:0]   count,
  output logic               overflow
);

  acc_state_t       r_state;
  acc_state_t       w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             w_accept;
  logic             w_handoff;
  logic             w_last;
  logic [ACC_W-1:0] w_word;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_count_inc;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign w_accept  = in_valid & in_ready;
  assign w_handoff = ena & out_ready & (r_state == DONE);

  // ---------------------------------------------------------------------------
  // Datapath: one extra bit on the adder exposes the carry out of bit ACC_W-1
  // ---------------------------------------------------------------------------
  assign w_word      = ACC_W'({in_carry, in_sum});
  // A fresh batch starts from zero regardless of what r_acc holds.
  assign w_base      = (r_state == IDLE) ? '0 : r_acc;
  assign w_sum       = {1'b0, w_base} + {1'b0, w_word};
  assign w_carry     = w_sum[ACC_W];
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_last      = (w_count_inc == CNT_W'(N_SAMPLES));

`ifdef ADDER8_ACCUM_SAT_EN
  // Once saturated the total is pinned at full scale until the batch ends.
  assign w_acc_next = (w_carry | r_overflow) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (ena) begin
      if (clear) begin
        w_state_next = IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_accept) w_state_next = (N_SAMPLES == 1) ? DONE : ACCUM;
          end
          ACCUM: begin
            if (w_accept && w_last) w_state_next = DONE;
          end
          DONE: begin
            if (out_ready) w_state_next = IDLE;
          end
          default: w_state_next = IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = ena & (r_state != DONE);
    out_valid = (r_state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Accumulator, counter and sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (ena) begin
      if (clear || w_handoff) begin
        // clear outranks both a pending accept and a pending handoff.
        r_acc      <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        r_acc      <= w_acc_next;
        r_count    <= w_count_inc;
        r_overflow <= r_overflow | w_carry;
      end
    end
  end

  assign acc      = r_acc;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule : adder8_accum

// File: tb/tb_adder8_accum.sv
module tb_adder8_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [7:0] in_sum;
  logic       in_carry;
  logic       in_ready;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] acc;
  logic [2:0] count;
  logic       overflow;

  // Second instance with a narrow accumulator for the overflow case.
  logic       in_valid10;
  logic       in_ready10;
  logic       out_valid10;
  logic       out_ready10;
  logic [9:0] acc10;
  logic [2:0] count10;
  logic       overflow10;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] acc;
    logic [2:0]  count;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        c;
    logic [7:0]  s;
    logic [15:0] exp_acc;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  adder8_accum u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .count     (count),
    .overflow  (overflow)
  );

  adder8_accum #(.ACC_W(10)) u_dut10 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid10),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_ready  (in_ready10),
    .clear     (clear),
    .out_valid (out_valid10),
    .out_ready (out_ready10),
    .acc       (acc10),
    .count     (count10),
    .overflow  (overflow10)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one word to u_dut; caller is positioned just after a rising edge.
  task automatic send(input logic c, input logic [7:0] s,
                      input logic [15:0] e_acc, input logic [2:0] e_cnt, input logic e_ovf);
    exp_t e;
    exp_t got;
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    in_carry = c;
    in_sum   = s;
    in_valid = 1'b1;
    e.acc = e_acc; e.count = e_cnt; e.ovf = e_ovf;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = sb.pop_front();
    check("send_acc",   32'(acc),      32'(got.acc));
    check("send_count", 32'(count),    32'(got.count));
    check("send_ovf",   32'(overflow), 32'(got.ovf));
    $display("txn w=%0d acc=%0d count=%0d ovf=%0d", {c, s}, acc, count, overflow);
  endtask

  initial begin
    int m_acc;
    bit m_ovf;

    vecs[0] = '{c: 1'b0, s: 8'd19,  exp_acc: 16'd19,  exp_cnt: 3'd1};
    vecs[1] = '{c: 1'b0, s: 8'd255, exp_acc: 16'd274, exp_cnt: 3'd2};
    vecs[2] = '{c: 1'b0, s: 8'd255, exp_acc: 16'd529, exp_cnt: 3'd3};
    vecs[3] = '{c: 1'b1, s: 8'd0,   exp_acc: 16'd785, exp_cnt: 3'd4};

    rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0;
    clear = 1'b0; out_ready = 1'b0; in_valid10 = 1'b0; out_ready10 = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc",       32'(acc),       32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_ovf",       32'(overflow),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready_ena0", 32'(in_ready), 32'd0);
    ena = 1'b1; #1;
    check("rst_in_ready_ena1", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- basic batch ----------------
    for (int i = 0; i < 4; i++)
      send(vecs[i].c, vecs[i].s, vecs[i].exp_acc, vecs[i].exp_cnt, 1'b0);
    check("batch_out_valid", 32'(out_valid), 32'd1);
    check("batch_acc",       32'(acc),       32'h311);
    check("batch_in_ready",  32'(in_ready),  32'd0);

    // ---------------- backpressure ----------------
    in_valid = 1'b1; in_carry = 1'b0; in_sum = 8'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_acc",       32'(acc),       32'h311);
      check("bp_count",     32'(count),     32'd4);
      check("bp_in_ready",  32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_acc",       32'(acc),       32'd0);
    check("release_count",     32'(count),     32'd0);
    check("release_in_ready",  32'(in_ready),  32'd1);

    // ---------------- overflow, ACC_W=10 ----------------
    m_acc = 0; m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_carry = 1'b1; in_sum = 8'd255; in_valid10 = 1'b1;
      m_acc = m_acc + 511;
      if (m_acc >= 1024) begin
        m_ovf = 1'b1;
`ifdef ADDER8_ACCUM_SAT_EN
        m_acc = 1023;
`else
        m_acc = m_acc - 1024;
`endif
      end
`ifdef ADDER8_ACCUM_SAT_EN
      if (m_ovf) m_acc = 1023;
`endif
      @(posedge clk); #1;
      in_valid10 = 1'b0;
      check("ovf_acc",   32'(acc10),      32'(m_acc));
      check("ovf_count", 32'(count10),    32'(i + 1));
      check("ovf_flag",  32'(overflow10), 32'(m_ovf));
      $display("txn10 w=511 acc=%0d count=%0d ovf=%0d", acc10, count10, overflow10);
    end
`ifdef ADDER8_ACCUM_SAT_EN
    check("ovf_final_acc", 32'(acc10), 32'd1023);
`else
    check("ovf_final_acc", 32'(acc10), 32'd1020);
`endif
    check("ovf_out_valid", 32'(out_valid10), 32'd1);
    out_ready10 = 1'b1;
    @(posedge clk); #1;
    out_ready10 = 1'b0;
    check("ovf_release_ovf", 32'(overflow10), 32'd0);
    check("ovf_release_acc", 32'(acc10),      32'd0);

    // ---------------- clear mid-batch ----------------
    send(1'b0, 8'd19,  16'd19,  3'd1, 1'b0);
    send(1'b0, 8'd255, 16'd274, 3'd2, 1'b0);
    in_valid = 1'b1; in_sum = 8'd100; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    check("clear_acc",      32'(acc),      32'd0);
    check("clear_count",    32'(count),    32'd0);
    check("clear_in_ready", 32'(in_ready), 32'd1);
    send(1'b0, 8'd7, 16'd7, 3'd1, 1'b0);

    // ---------------- ena gating ----------------
    ena = 1'b0; in_valid = 1'b1; in_carry = 1'b0; in_sum = 8'd9;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("ena_in_ready", 32'(in_ready), 32'd0);
      check("ena_acc",      32'(acc),      32'd7);
      check("ena_count",    32'(count),    32'd1);
    end
    ena = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ena_resume_acc",   32'(acc),   32'd16);
    check("ena_resume_count", 32'(count), 32'd2);

    // ---------------- async reset mid-ACCUM ----------------
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_acc",       32'(acc),       32'd0);
    check("arst_count",     32'(count),     32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b1, 8'd3, 16'd259, 3'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adder8_accum
